// File: rtl/debug_sequencer.sv
// Run-control and state-dump sequencer for the five-stage MIPS core.
// Gates the pipeline enable from UART commands and streams a PC + register-file snapshot back out.
module debug_sequencer #(
  parameter int         N_REGS   = 32,
  parameter logic [7:0] CMD_RUN  = 8'h63,
  parameter logic [7:0] CMD_STEP = 8'h73,
  parameter logic [7:0] CMD_DUMP = 8'h72
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_valid,
  input  logic                     i_tx_ready,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_pipe_halted,
  input  logic [31:0]              i_pc,
  input  logic [32*N_REGS-1:0]     i_registers,
  output logic                     o_pipe_enable,
  output logic                     o_busy
);

  localparam int               TOTAL_BYTES = 4 + 4 * N_REGS;
  localparam int               IDX_W       = $clog2(TOTAL_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(TOTAL_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    SNAP,
    SEND
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] byte_idx;
  logic [7:0]       shadow [TOTAL_BYTES];
  logic             tx_fire;

  assign tx_fire = (state == SEND) && i_tx_ready;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A halted core must never be clocked again, so exec commands skip straight to the dump.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_RUN) begin
            state_next = i_pipe_halted ? SNAP : RUN;
          end else if (i_rx_data == CMD_STEP) begin
            state_next = i_pipe_halted ? SNAP : STEP;
          end else if (i_rx_data == CMD_DUMP) begin
            state_next = SNAP;
          end
        end
      end
      RUN: begin
        if (i_pipe_halted) begin
          state_next = SNAP;
        end
      end
      STEP:    state_next = SNAP;
      SNAP:    state_next = SEND;
      SEND: begin
        if (tx_fire && (byte_idx == LAST_IDX)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow is stored in transmit order: PC MSB first, then reg0..regN-1 each MSB first.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      byte_idx <= '0;
      for (int i = 0; i < TOTAL_BYTES; i++) begin
        shadow[i] <= 8'h00;
      end
    end else if (state == SNAP) begin
      byte_idx <= '0;
      for (int j = 0; j < 4; j++) begin
        shadow[j] <= i_pc[8*(3-j) +: 8];
      end
      for (int k = 0; k < N_REGS; k++) begin
        for (int j = 0; j < 4; j++) begin
          shadow[4 + 4*k + j] <= i_registers[32*k + 8*(3-j) +: 8];
        end
      end
    end else if (tx_fire && (byte_idx != LAST_IDX)) begin
      byte_idx <= byte_idx + IDX_W'(1);
    end
  end

  always_comb begin
    o_pipe_enable = 1'b0;
    o_busy        = 1'b1;
    o_tx_valid    = 1'b0;
    o_tx_data     = 8'h00;
    case (state)
      IDLE: o_busy        = 1'b0;
      RUN:  o_pipe_enable = 1'b1;
      STEP: o_pipe_enable = 1'b1;
      SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = shadow[byte_idx];
      end
      default: ;
    endcase
  end

endmodule
